mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 42 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_F = 1'b1;

  localparam int DEFAULT_DEPTH = 256;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between the data (d) and fetch (f) ports.
// MEM_ARB_ROUND_ROBIN_EN adds a last-granted pointer; otherwise d has fixed priority.
module mem_arb_sel
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
  input  logic i_take,
`endif
  input  logic i_d_req,
  input  logic i_f_req,
  output logic o_win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Starting from "f granted last" makes d the favoured port out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= PORT_F;
    end else if (i_take) begin
      r_last <= o_win;
    end
  end

  always_comb begin
    o_win = PORT_F;
    if (i_d_req && i_f_req) begin
      o_win = other_port(r_last);
    end else if (i_d_req) begin
      o_win = PORT_D;
    end
  end
`else
  always_comb begin
    o_win = i_d_req ? PORT_D : PORT_F;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one access in flight, grant -> command -> ack over three cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed d priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          f_req,
  input  logic          d_we,
  input  logic          f_we,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] f_addr,
  input  logic [63:0]   d_wdata,
  input  logic [63:0]   f_wdata,
  output logic          d_gnt,
  output logic          f_gnt,
  output logic          d_ack,
  output logic          f_ack,
  output logic [63:0]   rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [63:0]   mem_rdata,
  output state_t        dbg_state
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        r_state;
  logic          r_we;
  logic          r_oor;
  logic          r_id;

  logic          w_any;
  logic          w_win;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [63:0]   w_wdata;

  assign w_any   = d_req | f_req;
  assign w_we    = (w_win == PORT_F) ? f_we    : d_we;
  assign w_addr  = (w_win == PORT_F) ? f_addr  : d_addr;
  assign w_wdata = (w_win == PORT_F) ? f_wdata : d_wdata;

  assign dbg_state = r_state;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic w_take;
  assign w_take = (r_state == ST_IDLE) && w_any;
`endif

  mem_arb_sel u_sel (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .rst     (rst),
    .i_take  (w_take),
`endif
    .i_d_req (d_req),
    .i_f_req (f_req),
    .o_win   (w_win)
  );

  // Pulse outputs default low every cycle; the case arms raise them for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_oor     <= 1'b0;
      r_id      <= PORT_D;
      d_gnt     <= 1'b0;
      f_gnt     <= 1'b0;
      d_ack     <= 1'b0;
      f_ack     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      d_gnt     <= 1'b0;
      f_gnt     <= 1'b0;
      d_ack     <= 1'b0;
      f_ack     <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            d_gnt     <= (w_win == PORT_D);
            f_gnt     <= (w_win == PORT_F);
            r_id      <= w_win;
            r_we      <= w_we;
            r_oor     <= (w_addr >= DEPTH_A);
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            r_state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          // Out-of-range accesses never reach the memory.
          if (!r_oor) begin
            mem_write <= r_we;
            mem_read  <= !r_we;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (!r_we && !r_oor) begin
            rdata <= mem_rdata;
          end
          err     <= r_oor;
          d_ack   <= (r_id == PORT_D);
          f_ack   <= (r_id == PORT_F);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester queues, a cycle-schedule reference model and per-cycle compare.
// Build with or without MEM_ARB_ROUND_ROBIN_EN; contention expectations follow the macro.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 64;
  localparam int SZ = 4096;

  logic          clk;
  logic          rst;
  logic          d_req, f_req, d_we, f_we;
  logic [AW-1:0] d_addr, f_addr;
  logic [63:0]   d_wdata, f_wdata;
  logic          d_gnt, f_gnt, d_ack, f_ack, err;
  logic [63:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_read, mem_write;
  logic [63:0]   mem_rdata;
  state_t        dbg_state;

  mem_arbiter #(.DEPTH(256), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .f_req(f_req), .d_we(d_we), .f_we(f_we),
    .d_addr(d_addr), .f_addr(f_addr), .d_wdata(d_wdata), .f_wdata(f_wdata),
    .d_gnt(d_gnt), .f_gnt(f_gnt), .d_ack(d_ack), .f_ack(f_ack),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory: word i holds 52*i+1 ----------------
  logic [63:0] tb_mem [0:255];
  initial for (int i = 0; i < 256; i++) tb_mem[i] = 64'(52 * i + 1);
  assign mem_rdata = (mem_addr < 64'd256) ? tb_mem[mem_addr[7:0]] : 64'd0;

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;
  txn_t d_q[$];
  txn_t f_q[$];

  // Hold req and payload until a grant is seen, then move to the next queued access.
  always @(negedge clk) begin
    if (d_req && d_gnt) void'(d_q.pop_front());
    if (f_req && f_gnt) void'(f_q.pop_front());
    if (d_q.size() > 0) begin
      d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
    end else begin
      d_req = 1'b0;
    end
    if (f_q.size() > 0) begin
      f_req = 1'b1; f_we = f_q[0].we; f_addr = f_q[0].addr; f_wdata = f_q[0].wdata;
    end else begin
      f_req = 1'b0;
    end
  end

  // ---------------- reference model: per-cycle event schedule ----------------
  typedef struct packed {
    logic        gd, gf, rd, wr, ad, af, er, upd;
    logic [63:0] rv;
  } sched_t;
  sched_t      sched [SZ];
  int          cyc = 0;
  int          free_at = 0;
  logic        m_last;
  logic        m_w, m_we, m_oor;
  logic [63:0] m_addr, m_wdata;
  logic [63:0] exp_addr, exp_wdata, exp_rdata;

  task automatic model_reset();
    foreach (sched[i]) sched[i] = '0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rdata = '0;
    free_at   = 0;
    m_last    = PORT_F;
  endtask

  // An accepted access occupies three cycles: grant now, command next, ack after that.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      model_reset();
    end else begin
      if (sched[cyc % SZ].upd) exp_rdata = sched[cyc % SZ].rv;
      if (cyc >= free_at && (d_req || f_req)) begin
        if (d_req && f_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_w = (m_last == PORT_D) ? PORT_F : PORT_D;
`else
          m_w = PORT_D;
`endif
        end else begin
          m_w = d_req ? PORT_D : PORT_F;
        end
        m_last  = m_w;
        m_we    = (m_w == PORT_F) ? f_we : d_we;
        m_addr  = (m_w == PORT_F) ? f_addr : d_addr;
        m_wdata = (m_w == PORT_F) ? f_wdata : d_wdata;
        m_oor   = (m_addr >= 64'd256);
        sched[cyc % SZ].gd       = (m_w == PORT_D);
        sched[cyc % SZ].gf       = (m_w == PORT_F);
        sched[(cyc + 1) % SZ].rd = !m_we && !m_oor;
        sched[(cyc + 1) % SZ].wr = m_we && !m_oor;
        sched[(cyc + 2) % SZ].ad = (m_w == PORT_D);
        sched[(cyc + 2) % SZ].af = (m_w == PORT_F);
        sched[(cyc + 2) % SZ].er = m_oor;
        sched[(cyc + 2) % SZ].upd = !m_we && !m_oor;
        sched[(cyc + 2) % SZ].rv = m_oor ? 64'd0 : tb_mem[m_addr[7:0]];
        exp_addr  = m_addr;
        exp_wdata = m_wdata;
        free_at   = cyc + 3;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic   gseq[$];
  sched_t cur;

  always @(posedge clk) begin
    #1;
    cur = sched[cyc % SZ];
    chk("d_gnt", 64'(d_gnt), 64'(cur.gd));
    chk("f_gnt", 64'(f_gnt), 64'(cur.gf));
    chk("mem_read", 64'(mem_read), 64'(cur.rd));
    chk("mem_write", 64'(mem_write), 64'(cur.wr));
    chk("d_ack", 64'(d_ack), 64'(cur.ad));
    chk("f_ack", 64'(f_ack), 64'(cur.af));
    chk("err", 64'(err), 64'(cur.er));
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("rdata", rdata, exp_rdata);
    if (d_gnt) gseq.push_back(PORT_D);
    if (f_gnt) gseq.push_back(PORT_F);
    sched[cyc % SZ] = '0;
  end

  // ---------------- directed tests ----------------
  task automatic wait_gnt(input logic port, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      waited++;
      if ((port == PORT_D) ? d_gnt : f_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_within_budget", 64'(ok), 64'd1);
  endtask

  task automatic push(input logic port, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (port == PORT_D) d_q.push_back(t);
    else f_q.push_back(t);
  endtask

  logic exp_seq [4];
  int   waited;

  initial begin
    rst = 1'b1;
    d_req = 0; f_req = 0; d_we = 0; f_we = 0;
    d_addr = '0; f_addr = '0; d_wdata = '0; f_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // reset state
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // single read of word 5
    @(posedge clk); #2;
    push(PORT_D, 1'b0, 64'd5, 64'd0);
    wait_gnt(PORT_D, waited);
    @(posedge clk); #1;
    chk("rd_mem_read", 64'(mem_read), 64'd1);
    chk("rd_mem_addr", mem_addr, 64'd5);
    @(posedge clk); #1;
    chk("rd_d_ack", 64'(d_ack), 64'd1);
    chk("rd_rdata", rdata, 64'd261);
    chk("rd_err", 64'(err), 64'd0);

    // write on fetch port
    #1 push(PORT_F, 1'b1, 64'd10, 64'hDEAD);
    wait_gnt(PORT_F, waited);
    @(posedge clk); #1;
    chk("wr_mem_write", 64'(mem_write), 64'd1);
    chk("wr_mem_read", 64'(mem_read), 64'd0);
    chk("wr_mem_addr", mem_addr, 64'd10);
    chk("wr_mem_wdata", mem_wdata, 64'hDEAD);
    @(posedge clk); #1;
    chk("wr_f_ack", 64'(f_ack), 64'd1);
    chk("wr_rdata_held", rdata, 64'd261);

    // out-of-range read at exactly DEPTH
    #1 push(PORT_D, 1'b0, 64'd256, 64'd0);
    wait_gnt(PORT_D, waited);
    @(posedge clk); #1;
    chk("oor_no_read", 64'(mem_read), 64'd0);
    chk("oor_no_write", 64'(mem_write), 64'd0);
    @(posedge clk); #1;
    chk("oor_d_ack", 64'(d_ack), 64'd1);
    chk("oor_err", 64'(err), 64'd1);
    chk("oor_rdata_held", rdata, 64'd261);

    // last in-range word
    #1 push(PORT_D, 1'b0, 64'd255, 64'd0);
    wait_gnt(PORT_D, waited);
    repeat (2) @(posedge clk);
    #1;
    chk("top_rdata", rdata, 64'd13261);
    chk("top_err", 64'(err), 64'd0);

    // reset during the command cycle
    #1 push(PORT_D, 1'b0, 64'd7, 64'd0);
    wait_gnt(PORT_D, waited);
    @(posedge clk); #1;
    chk("mid_mem_read_before", 64'(mem_read), 64'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_mem_read_async", 64'(mem_read), 64'd0);
    chk("mid_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("mid_rdata_clr", rdata, 64'd0);
    push(PORT_F, 1'b1, 64'd3, 64'h77);
    @(posedge clk);
    #3 rst = 1'b0;
    wait_gnt(PORT_F, waited);
    chk("post_rst_gnt_latency", 64'(waited), 64'd1);
    @(posedge clk); #1;
    chk("post_rst_d_ack", 64'(d_ack), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_f_ack", 64'(f_ack), 64'd1);

    // contention after a clean reset
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    gseq.delete();
    push(PORT_D, 1'b0, 64'd1, 64'd0);
    push(PORT_D, 1'b0, 64'd2, 64'd0);
    push(PORT_F, 1'b1, 64'd20, 64'hAA);
    push(PORT_F, 1'b0, 64'd30, 64'd0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{PORT_D, PORT_F, PORT_D, PORT_F};
`else
    exp_seq = '{PORT_D, PORT_D, PORT_F, PORT_F};
`endif
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (gseq.size() >= 4) break;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("cont_grants", 64'(gseq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_order_%0d", i), 64'((i < gseq.size()) ? gseq[i] : 1'bx),
          64'(exp_seq[i]));
    end
    chk("cont_rdata", rdata, 64'd1561);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
